// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: f3Br encodings, BHT counter type and reset value, funct3 validity helper
package branch_resolve_unit_pkg;
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } f3_br_e;
  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_RESET = 2'b01;
  function automatic logic f3_br_valid(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction
endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// branch_cmp: combinational funct3/rs1/rs2 -> taken, illegal (010/011 never taken)
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);
  logic eq, lt, ltu, base;
  assign eq      = rs1 == rs2;
  assign lt      = $signed(rs1) < $signed(rs2);
  assign ltu     = rs1 < rs2;
  // Odd funct3 is the inverted form of the even one (NE/GE/GEU).
  assign base    = funct3[2] ? (funct3[1] ? ltu : lt) : eq;
  assign illegal = !f3_br_valid(funct3);
  assign taken   = !illegal & (base ^ funct3[0]);
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: bimodal BHT lookup (clk, rst, pred_*) and one-stage branch resolution (ex_*, flush -> res_*)
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int BHT_DEPTH  = 64,
  parameter int PREDICT_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic            flush,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispred,
  output logic            res_illegal,
  output logic [XLEN-1:0] res_target
);
  localparam int IDX = $clog2(BHT_DEPTH);
  logic            cmp_taken, cmp_illegal, capture;
  logic            res_valid_d, res_taken_d, res_mispred_d, res_illegal_d;
  logic            res_valid_q, res_taken_q, res_mispred_q, res_illegal_q;
  logic [XLEN-1:0] res_target_d, res_target_q;
  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3  (ex_funct3),
    .rs1     (ex_rs1),
    .rs2     (ex_rs2),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );
  assign capture = ex_valid & ex_branch & ~flush;
  always_comb begin
    res_valid_d   = capture;
    res_taken_d   = capture & cmp_taken;
    res_mispred_d = capture & (cmp_taken ^ ex_pred_taken);
    res_illegal_d = capture & cmp_illegal;
    res_target_d  = capture ? (cmp_taken ? ex_pc + ex_imm : ex_pc + XLEN'(4)) : res_target_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_mispred_q <= 1'b0;
      res_illegal_q <= 1'b0;
      res_target_q  <= '0;
    end else begin
      res_valid_q   <= res_valid_d;
      res_taken_q   <= res_taken_d;
      res_mispred_q <= res_mispred_d;
      res_illegal_q <= res_illegal_d;
      res_target_q  <= res_target_d;
    end
  end
  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign res_mispred = res_mispred_q;
  assign res_illegal = res_illegal_q;
  assign res_target  = res_target_q;
  if (PREDICT_EN != 0) begin : g_bht
    bht_ctr_t [BHT_DEPTH-1:0] bht_q, bht_d;
    logic [IDX-1:0]           pred_idx, ex_idx;
    logic                     unused_pred_pc;
    assign pred_idx       = pred_pc[IDX+1:2];
    assign ex_idx         = ex_pc[IDX+1:2];
    assign unused_pred_pc = ^{pred_pc[XLEN-1:IDX+2], pred_pc[1:0]};
    // Saturating 2-bit counter; lookup reads bht_q so an update lands next cycle.
    always_comb begin
      bht_d = bht_q;
      if (capture & ~cmp_illegal)
        bht_d[ex_idx] = cmp_taken ? (bht_q[ex_idx] == 2'b11 ? 2'b11 : bht_q[ex_idx] + 2'd1)
                                  : (bht_q[ex_idx] == 2'b00 ? 2'b00 : bht_q[ex_idx] - 2'd1);
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) bht_q <= {BHT_DEPTH{BHT_RESET}};
      else     bht_q <= bht_d;
    end
    assign pred_taken = pred_valid & bht_q[pred_idx][1];
  end else begin : g_static
    logic unused_pred;
    assign unused_pred = ^{pred_valid, pred_pc};
    assign pred_taken  = 1'b0;
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table vectors, directed corner sequences and random stimulus against a behavioural model
module tb_branch_resolve_unit;
  localparam int XLEN = 32;
  logic            clk = 1'b0;
  logic            rst;
  logic            pred_valid, pred_taken, ex_valid, ex_branch, ex_pred_taken, flush;
  logic [XLEN-1:0] pred_pc, ex_rs1, ex_rs2, ex_pc, ex_imm, res_target;
  logic [2:0]      ex_funct3;
  logic            res_valid, res_taken, res_mispred, res_illegal;
  int              n_cmp = 0, n_bad = 0;
  int              ctr[64];
  logic [31:0]     exp_target = '0;
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, pc, imm;
    logic        hint, taken, mispred, illegal;
    logic [31:0] target;
  } vec_t;
  vec_t tbl[$];

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(64), .PREDICT_EN(1)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
    .flush(flush), .res_valid(res_valid), .res_taken(res_taken), .res_mispred(res_mispred),
    .res_illegal(res_illegal), .res_target(res_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_cmp(input logic [2:0] f3, input logic [31:0] a, b,
                                    output logic tk, output logic ill);
    ill = 1'b0;
    case (f3)
      3'd0:    tk = a == b;
      3'd1:    tk = a != b;
      3'd4:    tk = $signed(a) < $signed(b);
      3'd5:    tk = $signed(a) >= $signed(b);
      3'd6:    tk = a < b;
      3'd7:    tk = a >= b;
      default: begin tk = 1'b0; ill = 1'b1; end
    endcase
  endfunction

  task automatic drive(input logic v, br, input logic [2:0] f3, input logic [31:0] a, b, pc, imm,
                       input logic hint, fl);
    ex_valid = v; ex_branch = br; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = hint; flush = fl;
  endtask

  // Called just after a falling edge with inputs already driven; ends on the next falling edge.
  task automatic cycle();
    logic cap, tk, ill, hint;
    int   i;
    #1 chk("pred_taken", pred_taken, pred_valid && ctr[pred_pc[7:2]] >= 2);
    cap  = ex_valid && ex_branch && !flush;
    hint = ex_pred_taken;
    model_cmp(ex_funct3, ex_rs1, ex_rs2, tk, ill);
    @(posedge clk);
    if (cap) begin
      i = int'(ex_pc[7:2]);
      if (!ill) ctr[i] = tk ? (ctr[i] == 3 ? 3 : ctr[i] + 1) : (ctr[i] == 0 ? 0 : ctr[i] - 1);
      exp_target = tk ? ex_pc + ex_imm : ex_pc + 32'd4;
    end
    @(negedge clk);
    chk("res_valid", res_valid, cap);
    chk("res_taken", res_taken, cap && tk);
    chk("res_mispred", res_mispred, cap && (tk != hint));
    chk("res_illegal", res_illegal, cap && ill);
    chk("res_target", res_target, exp_target);
  endtask

  task automatic br80(input logic taken_dir);
    drive(1, 1, 3'd0, 32'h5, taken_dir ? 32'h5 : 32'h6, 32'h80, 32'h40, 0, 0);
    cycle();
  endtask

  initial begin
    foreach (ctr[i]) ctr[i] = 1;
    rst = 1'b1; pred_valid = 1'b1; pred_pc = 32'h100;
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_taken", res_taken, 0);
    chk("rst_res_mispred", res_mispred, 0);
    chk("rst_res_illegal", res_illegal, 0);
    chk("rst_res_target", res_target, 0);
    chk("rst_pred_0x100", pred_taken, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      pred_pc = 32'(i) << 2;
      #1 chk("rst_bht_entry", pred_taken, 0);
    end
    // Training at pc 0x80 (index 32).
    pred_pc = 32'h80;
    br80(1);
    chk("train1_pred", pred_taken, 1);
    br80(1);
    br80(1);
    br80(0);
    chk("train_nt_pred", pred_taken, 1);
    br80(0);
    chk("train_nt2_pred", pred_taken, 0);
    // Flush must not capture or train (counter at 01 would move to 10).
    drive(1, 1, 3'd0, 32'h5, 32'h5, 32'h80, 32'h40, 0, 1);
    cycle();
    chk("flush_res_valid", res_valid, 0);
    chk("flush_pred", pred_taken, 0);
    br80(1);
    chk("retrain_pred", pred_taken, 1);
    // Illegal funct3 at counter 10: no training, so prediction stays taken.
    drive(1, 1, 3'b010, 32'h5, 32'h5, 32'h80, 32'h40, 0, 0);
    cycle();
    chk("illegal_flag", res_illegal, 1);
    chk("illegal_taken", res_taken, 0);
    chk("illegal_pred", pred_taken, 1);
    // Directed vectors with hand-computed results.
    tbl.push_back('{3'd4, 32'hFEDCBA98, 32'h12345678, 32'h300, 32'h10, 0, 1, 1, 0, 32'h310});
    tbl.push_back('{3'd6, 32'hFEDCBA98, 32'h12345678, 32'h300, 32'h10, 0, 0, 0, 0, 32'h304});
    tbl.push_back('{3'd7, 32'hFEDCBA98, 32'h12345678, 32'h300, 32'h10, 1, 1, 0, 0, 32'h310});
    tbl.push_back('{3'd0, 32'hAAAA5555, 32'hAAAA5555, 32'h200, 32'h40, 0, 1, 1, 0, 32'h240});
    tbl.push_back('{3'd0, 32'hAAAA5555, 32'hAAAA5554, 32'h200, 32'h40, 0, 0, 0, 0, 32'h204});
    tbl.push_back('{3'd1, 32'h1, 32'h2, 32'h200, 32'h40, 1, 1, 0, 0, 32'h240});
    tbl.push_back('{3'd5, 32'hFFFFFFFF, 32'h0, 32'h400, 32'h8, 1, 0, 1, 0, 32'h404});
    tbl.push_back('{3'd1, 32'h7, 32'h7, 32'hFFFFFFFC, 32'h20, 0, 0, 0, 0, 32'h0});
    tbl.push_back('{3'd0, 32'h3, 32'h3, 32'hFFFFFFF0, 32'h20, 0, 1, 1, 0, 32'h10});
    tbl.push_back('{3'b011, 32'h1, 32'h2, 32'h500, 32'h8, 1, 0, 1, 1, 32'h504});
    foreach (tbl[k]) begin
      drive(1, 1, tbl[k].f3, tbl[k].a, tbl[k].b, tbl[k].pc, tbl[k].imm, tbl[k].hint, 0);
      cycle();
      chk("tbl_taken", res_taken, tbl[k].taken);
      chk("tbl_mispred", res_mispred, tbl[k].mispred);
      chk("tbl_illegal", res_illegal, tbl[k].illegal);
      chk("tbl_target", res_target, tbl[k].target);
    end
    // Target holds while idle.
    drive(0, 1, 3'd0, 0, 0, 32'h900, 32'h4, 0, 0);
    cycle();
    chk("idle_target_hold", res_target, 32'h504);
    // Random stimulus, including back-to-back same-index branches.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = $urandom;
      pred_valid = $urandom_range(0, 3) != 0;
      pred_pc    = $urandom;
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
            a, $urandom_range(0, 3) == 0 ? a : $urandom,
            {24'h0, 2'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'b00},
            $urandom, 1'($urandom), $urandom_range(0, 7) == 0);
      cycle();
    end
    // Async reset between back-to-back captures; 0x80 is trained to taken first.
    pred_valid = 1'b1; pred_pc = 32'h80;
    br80(1);
    br80(1);
    chk("pre_rst_pred", pred_taken, 1);
    drive(1, 1, 3'd0, 32'h5, 32'h5, 32'h80, 32'h40, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", res_valid, 0);
    chk("async_rst_target", res_target, 0);
    chk("async_rst_pred", pred_taken, 0);
    @(negedge clk);
    chk("rst_held_valid", res_valid, 0);
    rst = 1'b0;
    foreach (ctr[i]) ctr[i] = 1;
    exp_target = '0;
    drive(1, 1, 3'd4, 32'hFEDCBA98, 32'h12345678, 32'h80, 32'h40, 0, 0);
    cycle();
    chk("post_rst_valid", res_valid, 1);
    chk("post_rst_target", res_target, 32'hC0);
    chk("post_rst_pred", pred_taken, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
